// File: rtl/uart_bridge_pkg.sv
// Shared types and byte constants for the UART register bridge.
package uart_bridge_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_GET_ADDR,
        ST_GET_DATA,
        ST_EXEC,
        ST_SEND
    } state_e;

    typedef enum logic {
        OP_RD = 1'b0,
        OP_WR = 1'b1
    } op_e;

    localparam logic [7:0] CMD_WR  = 8'h57;
    localparam logic [7:0] CMD_RD  = 8'h52;
    localparam logic [7:0] RSP_OK  = 8'h4B;
    localparam logic [7:0] RSP_ERR = 8'h45;

endpackage

// File: rtl/uart_bridge_regfile.sv
// Register file for the UART bridge: one write port, one combinational read
// port and a flattened view of every register.
module uart_bridge_regfile #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned NUM_REGS   = 16,
    parameter int unsigned AW         = 4
) (
    input  logic                           clk_i,
    input  logic                           rst_i,
    input  logic                           we_i,
    input  logic [AW-1:0]                  waddr_i,
    input  logic [DATA_WIDTH-1:0]          wdata_i,
    input  logic [AW-1:0]                  raddr_i,
    output logic [DATA_WIDTH-1:0]          rdata_o,
    output logic [NUM_REGS*DATA_WIDTH-1:0] regs_flat_o
);

    logic [DATA_WIDTH-1:0] regs_q [NUM_REGS];

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < int'(NUM_REGS); i++) begin
                regs_q[i] <= '0;
            end
        end else if (we_i) begin
            regs_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = regs_q[raddr_i];

    for (genvar g = 0; g < int'(NUM_REGS); g++) begin : g_flat
        assign regs_flat_o[g*DATA_WIDTH +: DATA_WIDTH] = regs_q[g];
    end

endmodule

// File: rtl/uart_reg_bridge.sv
// Host-side UART command responder: 'W' addr data / 'R' addr -> one response byte.
// Optional inter-byte timeout enabled by defining UART_BRIDGE_TIMEOUT_EN.
module uart_reg_bridge
    import uart_bridge_pkg::*;
#(
    parameter int unsigned DATA_WIDTH     = 8,
    parameter int unsigned NUM_REGS       = 16,
    parameter int unsigned TIMEOUT_CYCLES = 1000
) (
    input  logic                           UCLK,
    input  logic                           reset,
    input  logic [DATA_WIDTH-1:0]          R_data,
    input  logic                           rx_empty,
    output logic                           rd_uart,
    output logic [DATA_WIDTH-1:0]          W_data,
    input  logic                           tx_full,
    output logic                           wr_uart,
    output logic [NUM_REGS*DATA_WIDTH-1:0] regs_flat,
    output logic                           busy,
    output logic                           cmd_err
);

    localparam int unsigned AW = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;

    state_e                state_q, state_d;
    op_e                   op_q, op_d;
    logic [AW-1:0]         addr_q, addr_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic [DATA_WIDTH-1:0] resp_q, resp_d;
    logic                  err_q, err_d;
    logic                  reg_we;
    logic [DATA_WIDTH-1:0] reg_rdata;
    logic                  tmo_hit;

    assign rd_uart = ((state_q == ST_IDLE) || (state_q == ST_GET_ADDR) ||
                      (state_q == ST_GET_DATA)) && !rx_empty;
    assign wr_uart = (state_q == ST_SEND) && !tx_full;
    assign W_data  = resp_q;
    assign busy    = (state_q != ST_IDLE);
    assign cmd_err = (state_q == ST_EXEC) && err_q;

`ifdef UART_BRIDGE_TIMEOUT_EN
    localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);

    logic [TW-1:0] tmo_q, tmo_d;

    // Idle counter only runs while a command is partially received.
    always_comb begin
        tmo_d = tmo_q;
        if (rd_uart || (state_q == ST_IDLE) || (state_q == ST_EXEC) || (state_q == ST_SEND)) begin
            tmo_d = '0;
        end else if (tmo_q != TW'(TIMEOUT_CYCLES)) begin
            tmo_d = tmo_q + TW'(1);
        end
    end

    always_ff @(posedge UCLK or posedge reset) begin
        if (reset) begin
            tmo_q <= '0;
        end else begin
            tmo_q <= tmo_d;
        end
    end

    assign tmo_hit = (tmo_q == TW'(TIMEOUT_CYCLES));
`else
    assign tmo_hit = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        resp_d  = resp_q;
        err_d   = err_q;
        reg_we  = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (rd_uart) begin
                    if (R_data == DATA_WIDTH'(CMD_WR)) begin
                        op_d    = OP_WR;
                        err_d   = 1'b0;
                        state_d = ST_GET_ADDR;
                    end else if (R_data == DATA_WIDTH'(CMD_RD)) begin
                        op_d    = OP_RD;
                        err_d   = 1'b0;
                        state_d = ST_GET_ADDR;
                    end else begin
                        err_d   = 1'b1;
                        resp_d  = DATA_WIDTH'(RSP_ERR);
                        state_d = ST_EXEC;
                    end
                end
            end
            ST_GET_ADDR: begin
                if (rd_uart) begin
                    addr_d  = R_data[AW-1:0];
                    err_d   = (32'(R_data) >= NUM_REGS);
                    state_d = (op_q == OP_WR) ? ST_GET_DATA : ST_EXEC;
                end else if (tmo_hit) begin
                    state_d = ST_IDLE;
                end
            end
            ST_GET_DATA: begin
                if (rd_uart) begin
                    wdata_d = R_data;
                    state_d = ST_EXEC;
                end else if (tmo_hit) begin
                    state_d = ST_IDLE;
                end
            end
            ST_EXEC: begin
                state_d = ST_SEND;
                if (err_q) begin
                    resp_d = DATA_WIDTH'(RSP_ERR);
                end else if (op_q == OP_WR) begin
                    reg_we = 1'b1;
                    resp_d = DATA_WIDTH'(RSP_OK);
                end else begin
                    resp_d = reg_rdata;
                end
            end
            ST_SEND: begin
                if (wr_uart) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge UCLK or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            op_q    <= OP_RD;
            addr_q  <= '0;
            wdata_q <= '0;
            resp_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            resp_q  <= resp_d;
            err_q   <= err_d;
        end
    end

    uart_bridge_regfile #(
        .DATA_WIDTH (DATA_WIDTH),
        .NUM_REGS   (NUM_REGS),
        .AW         (AW)
    ) u_regfile (
        .clk_i       (UCLK),
        .rst_i       (reset),
        .we_i        (reg_we),
        .waddr_i     (addr_q),
        .wdata_i     (wdata_q),
        .raddr_i     (addr_q),
        .rdata_o     (reg_rdata),
        .regs_flat_o (regs_flat)
    );

endmodule

// File: tb/tb_uart_reg_bridge.sv
// Scoreboard bench for uart_reg_bridge: RX FIFO model feeds command bytes,
// a negedge monitor checks every TX push against queued expected responses.
module tb_uart_reg_bridge;

`ifdef UART_BRIDGE_TIMEOUT_EN
    localparam int unsigned TMO = 50;
`else
    localparam int unsigned TMO = 1000;
`endif

    typedef struct {
        logic [7:0] data;
        bit         lat;
    } exp_t;

    logic         UCLK = 1'b0;
    logic         reset;
    logic [7:0]   R_data;
    logic         rx_empty;
    logic         rd_uart;
    logic [7:0]   W_data;
    logic         tx_full;
    logic         wr_uart;
    logic [127:0] regs_flat;
    logic         busy;
    logic         cmd_err;

    logic [7:0]   rx_q[$];
    exp_t         exp_q[$];
    logic [127:0] mdl_regs;
    int           checks   = 0;
    int           failures = 0;
    int           cyc      = 0;
    int           last_pop = 0;
    int           err_cnt  = 0;
    bit           pop_now  = 1'b0;

    uart_reg_bridge #(
        .DATA_WIDTH     (8),
        .NUM_REGS       (16),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .UCLK      (UCLK),
        .reset     (reset),
        .R_data    (R_data),
        .rx_empty  (rx_empty),
        .rd_uart   (rd_uart),
        .W_data    (W_data),
        .tx_full   (tx_full),
        .wr_uart   (wr_uart),
        .regs_flat (regs_flat),
        .busy      (busy),
        .cmd_err   (cmd_err)
    );

    always #5 UCLK = ~UCLK;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    // RX FIFO model: head byte changes just after the edge that consumed it.
    always @(posedge UCLK) begin
        cyc++;
        #1;
        if (pop_now && rx_q.size() > 0) void'(rx_q.pop_front());
        pop_now  = 1'b0;
        rx_empty = (rx_q.size() == 0);
        R_data   = (rx_q.size() > 0) ? rx_q[0] : 8'h00;
    end

    // Monitor: checks each TX push against the scoreboard.
    always @(negedge UCLK) begin
        if (!reset) begin
            pop_now = rd_uart;
            if (rd_uart) last_pop = cyc;
            if (cmd_err) err_cnt++;
            if (wr_uart) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_push", {120'h0, W_data}, 128'h0);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    chk("resp", {120'h0, W_data}, {120'h0, e.data});
                    if (e.lat) chk("latency", 128'(cyc - last_pop), 128'd2);
                end
            end
        end
    end

    task automatic send(input logic [7:0] b);
        rx_q.push_back(b);
    endtask

    task automatic expect_resp(input logic [7:0] d, input bit lat);
        exp_t e;
        e.data = d;
        e.lat  = lat;
        exp_q.push_back(e);
    endtask

    task automatic wait_idle(input string name);
        int n = 0;
        do begin
            @(negedge UCLK);
            n++;
        end while (!(rx_q.size() == 0 && exp_q.size() == 0 && !busy) && n < 200);
        chk(name, {127'h0, (rx_q.size() == 0 && exp_q.size() == 0 && !busy)}, 128'h1);
    endtask

    task automatic wait_rx_drained(input string name);
        int n = 0;
        while (rx_q.size() != 0 && n < 100) begin
            @(negedge UCLK);
            n++;
        end
        chk(name, 128'(rx_q.size()), 128'h0);
    endtask

    initial begin
        int e0;
        int viol;
        reset    = 1'b1;
        tx_full  = 1'b0;
        R_data   = 8'h00;
        rx_empty = 1'b1;
        mdl_regs = '0;
        repeat (3) @(negedge UCLK);
        chk("reset_outs", {124'h0, rd_uart, wr_uart, busy, cmd_err}, 128'h0);
        chk("reset_regs", regs_flat, 128'h0);
        chk("reset_wdata", {120'h0, W_data}, 128'h0);
        reset = 1'b0;
        repeat (2) @(negedge UCLK);

        // Write 0xA5 to reg 3, then read it back.
        expect_resp(8'h4B, 1'b1);
        send(8'h57); send(8'h03); send(8'hA5);
        mdl_regs[31:24] = 8'hA5;
        wait_idle("wr3_done");
        chk("wr3_regs", regs_flat, mdl_regs);
        expect_resp(8'hA5, 1'b1);
        send(8'h52); send(8'h03);
        wait_idle("rd3_done");

        // Out-of-range read and write.
        e0 = err_cnt;
        expect_resp(8'h45, 1'b1);
        send(8'h52); send(8'h10);
        wait_idle("rd_bad_done");
        chk("rd_bad_errcnt", 128'(err_cnt - e0), 128'd1);
        chk("rd_bad_regs", regs_flat, mdl_regs);
        expect_resp(8'h45, 1'b1);
        send(8'h57); send(8'h20); send(8'hFF);
        wait_idle("wr_bad_done");
        chk("wr_bad_regs", regs_flat, mdl_regs);

        // Unknown opcode, then a normal read.
        e0 = err_cnt;
        expect_resp(8'h45, 1'b1);
        send(8'h33);
        wait_idle("unk_done");
        chk("unk_errcnt", 128'(err_cnt - e0), 128'd1);
        chk("unk_busy", {127'h0, busy}, 128'h0);
        expect_resp(8'h00, 1'b1);
        send(8'h52); send(8'h00);
        wait_idle("rd0_done");

        // TX backpressure during SEND with more bytes waiting in RX.
        tx_full = 1'b1;
        expect_resp(8'h4B, 1'b0);
        send(8'h57); send(8'h07); send(8'h3C);
        mdl_regs[63:56] = 8'h3C;
        wait_rx_drained("bp_drain");
        repeat (2) @(negedge UCLK);
        send(8'h52); send(8'h07);
        viol = 0;
        repeat (20) begin
            @(negedge UCLK);
            if (wr_uart || rd_uart || !busy) viol++;
        end
        chk("bp_hold", 128'(viol), 128'h0);
        chk("bp_regs", regs_flat, mdl_regs);
        expect_resp(8'h3C, 1'b1);
        tx_full = 1'b0;
        wait_idle("bp_done");

        // Reset in the middle of a write command.
        send(8'h57); send(8'h05);
        wait_rx_drained("rst_drain");
        @(negedge UCLK);
        chk("rst_mid_busy", {127'h0, busy}, 128'h1);
        reset = 1'b1;
        #1;
        chk("rst_mid_outs", {124'h0, rd_uart, wr_uart, busy, cmd_err}, 128'h0);
        repeat (2) @(negedge UCLK);
        reset    = 1'b0;
        mdl_regs = '0;
        repeat (10) @(negedge UCLK);
        chk("rst_busy", {127'h0, busy}, 128'h0);
        chk("rst_reg5", {120'h0, regs_flat[47:40]}, 128'h0);
        chk("rst_regs", regs_flat, mdl_regs);
        expect_resp(8'h00, 1'b1);
        send(8'h52); send(8'h05);
        wait_idle("rst_rd_done");

`ifdef UART_BRIDGE_TIMEOUT_EN
        // Abandoned command times out back to IDLE with no response.
        send(8'h57);
        repeat (60) @(negedge UCLK);
        chk("tmo_busy", {127'h0, busy}, 128'h0);
        chk("tmo_regs", regs_flat, mdl_regs);
        expect_resp(8'h00, 1'b1);
        send(8'h52); send(8'h00);
        wait_idle("tmo_rd_done");
`endif

        repeat (5) @(negedge UCLK);
        chk("scoreboard_empty", 128'(exp_q.size()), 128'h0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

endmodule
